serial_frame_ctrl: RTL and testbench

//  Sequencing controller for the single-bit serial frame path: watches the idle-high serial line,

---
 rtl/serial_ctrl_pkg.sv | 19 +
 rtl/serial_field_shifter.sv | 46 ++++
 rtl/serial_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the serial frame controller: FSM state encoding,
// default header field widths and the idle level of the serial line.
package serial_ctrl_pkg;

  localparam int unsigned PORT_W_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 4;
  localparam logic        IDLE_LEVEL = 1'b1;

  // PARITY is only reachable when SERIAL_FRAME_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PORT   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/serial_field_shifter.sv
// MSB-first shift-in register for one header field.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   i_clr            clear value and bit count
//   i_en             load-enable: shift i_bit in this cycle
//   i_bit            serial bit to shift in
//   o_next_c         field value including the bit being shifted this cycle
//   o_field_full_c   this cycle's shift completes the field
module serial_field_shifter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_next_c,
  output logic         o_field_full_c
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_value;
  logic [CW-1:0] r_cnt;
  logic          w_room;

  // Truncating cast drops the oldest bit, so W=1 needs no special case.
  assign o_next_c       = W'({r_value, i_bit});
  assign w_room         = (r_cnt != CW'(W));
  assign o_field_full_c = i_en && (r_cnt == CW'(W - 1));

  // Shift register and bit counter; counting stops once the field is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (i_en && w_room) begin
      r_value <= o_next_c;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame sequencing controller: detects a start bit on the idle-high
// line, captures the port-id and length header fields, forwards exactly LEN
// payload bits and pulses frame_done at the end of each frame.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   serial_in    serial line, idle high
//   port_sel     port id of the current/last frame
//   data_out     payload bit, qualified by data_valid
//   data_valid   data_out holds a payload bit
//   busy         controller is not idle
//   frame_done   one-cycle end-of-frame pulse
//   parity_err   (SERIAL_FRAME_PARITY_EN only) even-parity mismatch, valid with frame_done
// Build option: define SERIAL_FRAME_PARITY_EN to add a trailing parity bit.
module serial_frame_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int unsigned PORT_W = PORT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [PORT_W-1:0] port_sel,
  output logic              data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_done
`ifdef SERIAL_FRAME_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef SERIAL_FRAME_PARITY_EN
  localparam state_t ST_TAIL   = ST_PARITY;
  localparam logic   TAIL_DONE = 1'b0;
`else
  localparam state_t ST_TAIL   = ST_DONE;
  localparam logic   TAIL_DONE = 1'b1;
`endif

  state_t            r_state;
  logic [PORT_W-1:0] r_port_sel;
  logic [CNT_W-1:0]  r_len_cnt;
  logic              r_data_out;
  logic              r_data_valid;
  logic              r_busy;
  logic              r_frame_done;
`ifdef SERIAL_FRAME_PARITY_EN
  logic              r_par;
  logic              r_parity_err;
`endif

  logic              w_idle;
  logic              w_port_en;
  logic              w_len_en;
  logic [PORT_W-1:0] w_port_next;
  logic              w_port_full;
  logic [CNT_W-1:0]  w_len_next;
  logic              w_len_full;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_port_en = (r_state == ST_PORT);
  assign w_len_en  = (r_state == ST_LEN);

  serial_field_shifter #(.W(PORT_W)) u_port_shift (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_idle),
    .i_en           (w_port_en),
    .i_bit          (serial_in),
    .o_next_c       (w_port_next),
    .o_field_full_c (w_port_full)
  );

  serial_field_shifter #(.W(CNT_W)) u_len_shift (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_idle),
    .i_en           (w_len_en),
    .i_bit          (serial_in),
    .o_next_c       (w_len_next),
    .o_field_full_c (w_len_full)
  );

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_port_sel   <= '0;
      r_len_cnt    <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
`ifdef SERIAL_FRAME_PARITY_EN
          r_par <= 1'b0;
`endif
          if (serial_in != IDLE_LEVEL) begin
            r_state <= ST_PORT;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_PORT: begin
`ifdef SERIAL_FRAME_PARITY_EN
          r_par <= r_par ^ serial_in;
`endif
          if (w_port_full) begin
            r_port_sel <= w_port_next;
            r_state    <= ST_LEN;
          end
        end
        ST_LEN: begin
`ifdef SERIAL_FRAME_PARITY_EN
          r_par <= r_par ^ serial_in;
`endif
          if (w_len_full) begin
            r_len_cnt <= w_len_next;
            if (w_len_next == '0) begin
              r_state      <= ST_TAIL;
              r_frame_done <= TAIL_DONE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
`ifdef SERIAL_FRAME_PARITY_EN
          r_par <= r_par ^ serial_in;
`endif
          r_data_out   <= serial_in;
          r_data_valid <= 1'b1;
          r_len_cnt    <= r_len_cnt - CNT_W'(1);
          // Exit on the last bit so the counter never wraps past zero.
          if (r_len_cnt == CNT_W'(1)) begin
            r_state      <= ST_TAIL;
            r_frame_done <= TAIL_DONE;
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        ST_PARITY: begin
          r_parity_err <= r_par ^ serial_in;
          r_frame_done <= 1'b1;
          r_state      <= ST_DONE;
        end
`endif
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign port_sel   = r_port_sel;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
`ifdef SERIAL_FRAME_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: frames are laid out as a per-cycle bit
// timeline, and the expected outputs for each cycle are derived from the
// frame's field positions (start, port, length, payload, optional parity).
module tb_serial_frame_ctrl;

  localparam int unsigned P    = 2;
  localparam int unsigned C    = 4;
  localparam int unsigned MAXN = 4096;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         serial_in;
  logic [P-1:0] port_sel;
  logic         data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_done;
`ifdef SERIAL_FRAME_PARITY_EN
  logic         parity_err;
`endif

  serial_frame_ctrl #(.PORT_W(P), .CNT_W(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .port_sel   (port_sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SERIAL_FRAME_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Timeline: bit driven before edge k and outputs expected just after it.
  logic         s_bit  [MAXN];
  logic         e_busy [MAXN];
  logic         e_valid[MAXN];
  logic         e_data [MAXN];
  logic         e_done [MAXN];
  logic         e_perr [MAXN];
  logic [P-1:0] e_port [MAXN];
  int           n;
  logic [P-1:0] m_port;

  int n_total;
  int n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic b, input logic bsy, input logic v, input logic d,
                      input logic dn, input logic pe);
    s_bit[n]   = b;
    e_busy[n]  = bsy;
    e_valid[n] = v;
    e_data[n]  = d;
    e_done[n]  = dn;
    e_perr[n]  = pe;
    e_port[n]  = m_port;
    n++;
  endtask

  task automatic add_idle(input int cnt);
    for (int i = 0; i < cnt; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // pay[i] is the i-th payload bit on the line; flip inverts the parity bit.
  task automatic add_frame(input logic [P-1:0] port, input logic [C-1:0] len,
                           input logic [15:0] pay, input logic flip);
    logic par;
    int   l;
    par = 1'b0;
    l   = int'(len);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = int'(P) - 1; i >= 0; i--) begin
      par ^= port[i];
      if (i == 0) m_port = port;
      push(port[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = int'(C) - 1; i >= 0; i--) begin
      par ^= len[i];
      push(len[i], 1'b1, 1'b0, 1'b0, (!HAS_PAR && i == 0 && l == 0), 1'b0);
    end
    for (int i = 0; i < l; i++) begin
      par ^= pay[i];
      push(pay[i], 1'b1, 1'b1, pay[i], (!HAS_PAR && i == l - 1), 1'b0);
    end
    if (HAS_PAR) push(par ^ flip, 1'b1, 1'b0, 1'b0, 1'b1, flip);
    // Bit arriving while in DONE must be ignored, whatever its value.
    push(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_stream(input int upto);
    for (int k = 0; k < upto; k++) begin
      @(negedge clk);
      serial_in = s_bit[k];
      @(posedge clk);
      #1;
      check_eq("busy",       32'(busy),       32'(e_busy[k]));
      check_eq("data_valid", 32'(data_valid), 32'(e_valid[k]));
      check_eq("frame_done", 32'(frame_done), 32'(e_done[k]));
      check_eq("port_sel",   32'(port_sel),   32'(e_port[k]));
      if (e_valid[k]) check_eq("data_out", 32'(data_out), 32'(e_data[k]));
`ifdef SERIAL_FRAME_PARITY_EN
      check_eq("parity_err", 32'(parity_err), 32'(e_perr[k]));
`endif
    end
    n = 0;
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b0;
    serial_in = 1'b1;
    n_total   = 0;
    n_bad     = 0;
    n         = 0;
    m_port    = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_port_sel",   32'(port_sel),   32'd0);
    check_eq("rst_data_out",   32'(data_out),   32'd0);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef SERIAL_FRAME_PARITY_EN
    check_eq("rst_parity_err", 32'(parity_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Idle line for 20 cycles.
    add_idle(20);
    run_stream(n);

    // Port 2, three payload bits 1,0,1.
    add_frame(2'd2, 4'd3, 16'b101, 1'b0);
    add_idle(2);
    run_stream(n);

    // Port 3, zero-length frame.
    add_frame(2'd3, 4'd0, 16'h0, 1'b0);
    add_idle(2);
    run_stream(n);

    // Maximum length frame followed back-to-back by a one-bit frame.
    add_frame(2'd1, 4'd15, 16'($urandom), 1'b0);
    add_frame(2'd2, 4'd1, 16'h1, 1'b0);
    add_idle(1);
    run_stream(n);

`ifdef SERIAL_FRAME_PARITY_EN
    // Correct then wrong parity bit.
    add_frame(2'd2, 4'd2, 16'b11, 1'b0);
    add_frame(2'd2, 4'd2, 16'b11, 1'b1);
    add_idle(1);
    run_stream(n);
`endif

    // Random frames with random gaps (including back-to-back).
    for (int f = 0; f < 40; f++) begin
      add_frame(P'($urandom), C'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)) & HAS_PAR);
      add_idle(int'($urandom_range(0, 3)));
      run_stream(n);
    end

    // Reset during the second payload bit of a length-5 frame.
    add_frame(2'd1, 4'd5, 16'b10110, 1'b0);
    run_stream(8);
    @(negedge clk);
    serial_in = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_eq("abort_data_valid", 32'(data_valid), 32'd0);
    check_eq("abort_busy",       32'(busy),       32'd0);
    check_eq("abort_frame_done", 32'(frame_done), 32'd0);
    check_eq("abort_port_sel",   32'(port_sel),   32'd0);
    check_eq("abort_data_out",   32'(data_out),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_hold_done", 32'(frame_done), 32'd0);
    check_eq("abort_hold_busy", 32'(busy),       32'd0);
    @(negedge clk);
    rst    = 1'b1;
    m_port = '0;
    n      = 0;
    add_idle(3);
    add_frame(2'd3, 4'd4, 16'b1001, 1'b0);
    add_idle(2);
    run_stream(n);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
